// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word intake, start/data/parity/stop framing,
// registered TX line and a one-cycle done pulse at the end of every frame.
module uart_tx_frame #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W = $clog2(CYCLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 baud_tick;

    assign baud_tick = (baud_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the state being entered so tx changes on the same edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: four transmitter configurations (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] data_v [4];
    logic [3:0] valid_v;
    logic [3:0] tx_w, ready_w, busy_w, done_w;
    int         total = 0;
    int         bad = 0;
    logic [127:0] cap_tx, cap_busy, cap_ready, cap_done;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx_frame #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx_frame #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx_frame #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line waveform, one bit per clock, 10 clocks per symbol.
    function automatic logic [127:0] frame_wave(input logic [8:0] data, input int nb,
                                                input int haspar, input logic pbit, input int stops);
        logic [127:0] w;
        logic [11:0]  sym;
        int           n;
        int           k;
        w = '0;
        sym = '1;
        n = 0;
        sym[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin sym[n] = data[i]; n++; end
        if (haspar != 0) begin sym[n] = pbit; n++; end
        for (int i = 0; i < stops; i++) begin sym[n] = 1'b1; n++; end
        k = 0;
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < 10; c++) begin w[k] = sym[s]; k++; end
        end
        return w;
    endfunction

    task automatic send(input int idx, input logic [8:0] data, input bit hold);
        @(negedge clk);
        check("ready_before_send", 128'(ready_w[idx]), 128'd1);
        data_v[idx]  = data;
        valid_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid_v[idx] = 1'b0;
        $display("send inst=%0d data=%h", idx, data);
    endtask

    // mode 1 pokes a new word and changes tx_data while the frame is in flight.
    task automatic capture(input int idx, input int len, input int mode);
        cap_tx = '0; cap_busy = '0; cap_ready = '0; cap_done = '0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            cap_tx[k]    = tx_w[idx];
            cap_busy[k]  = busy_w[idx];
            cap_ready[k] = ready_w[idx];
            cap_done[k]  = done_w[idx];
            if (mode == 1) begin
                if (k == 30) begin data_v[idx] = 9'h012; valid_v[idx] = 1'b1; end
                if (k == 31) valid_v[idx] = 1'b0;
                if (k == 60) data_v[idx] = 9'h099;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int len, input logic [127:0] exp);
        logic [127:0] mask;
        mask = (128'd1 << len) - 128'd1;
        check({tag, "_tx"}, cap_tx, exp);
        check({tag, "_busy"}, cap_busy, mask);
        check({tag, "_ready"}, cap_ready, 128'd0);
        check({tag, "_done"}, cap_done, 128'd0);
        $display("frame %s len=%0d tx=%0h", tag, len, cap_tx);
    endtask

    task automatic frame_end(input string tag, input int idx);
        @(negedge clk);
        check({tag, "_end_done"}, 128'(done_w[idx]), 128'd1);
        check({tag, "_end_ready"}, 128'(ready_w[idx]), 128'd1);
        check({tag, "_end_busy"}, 128'(busy_w[idx]), 128'd0);
        check({tag, "_end_tx"}, 128'(tx_w[idx]), 128'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_v = '0;
        for (int i = 0; i < 4; i++) data_v[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 128'(tx_w), 128'hF);
        check("reset_ready", 128'(ready_w), 128'hF);
        check("reset_busy", 128'(busy_w), 128'h0);
        check("reset_done", 128'(done_w), 128'h0);
        rst_n = 1'b1;

        // 8N1 0x55
        send(0, 9'h055, 1'b0);
        capture(0, 100, 0);
        check_frame("t1", 100, frame_wave(9'h055, 8, 0, 1'b0, 1));
        frame_end("t1", 0);
        @(negedge clk);
        check("t1_done_single", 128'(done_w[0]), 128'd0);

        // 0x07: even parity bit 1, odd parity bit 0
        send(1, 9'h007, 1'b0);
        capture(1, 110, 0);
        check_frame("t2_even", 110, frame_wave(9'h007, 8, 1, 1'b1, 1));
        frame_end("t2_even", 1);
        send(2, 9'h007, 1'b0);
        capture(2, 110, 0);
        check_frame("t2_odd", 110, frame_wave(9'h007, 8, 1, 1'b0, 1));
        frame_end("t2_odd", 2);

        // 7N2 0x41
        send(3, 9'h041, 1'b0);
        capture(3, 100, 0);
        check_frame("t3", 100, frame_wave(9'h041, 7, 0, 1'b0, 2));
        frame_end("t3", 3);

        // back-to-back with tx_valid held high
        send(0, 9'h0A5, 1'b1);
        data_v[0] = 9'h03C;
        capture(0, 100, 0);
        check_frame("t4_a", 100, frame_wave(9'h0A5, 8, 0, 1'b0, 1));
        frame_end("t4_a", 0);
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        capture(0, 100, 0);
        check_frame("t4_b", 100, frame_wave(9'h03C, 8, 0, 1'b0, 1));
        frame_end("t4_b", 0);

        // reset during data bit 3 of 0xFF
        send(0, 9'h0FF, 1'b0);
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_tx_after_rst", 128'(tx_w[0]), 128'd1);
        check("t5_ready_after_rst", 128'(ready_w[0]), 128'd1);
        check("t5_busy_after_rst", 128'(busy_w[0]), 128'd0);
        capture(0, 120, 0);
        check("t5_no_done", cap_done, 128'd0);
        check("t5_line_idle", cap_tx, (128'd1 << 120) - 128'd1);
        send(0, 9'h0C3, 1'b0);
        capture(0, 100, 0);
        check_frame("t5_next", 100, frame_wave(9'h0C3, 8, 0, 1'b0, 1));
        frame_end("t5_next", 0);

        // mid-frame valid pulse and tx_data change are ignored
        send(0, 9'h034, 1'b0);
        capture(0, 100, 1);
        check_frame("t6", 100, frame_wave(9'h034, 8, 0, 1'b0, 1));
        frame_end("t6", 0);
        repeat (2) @(negedge clk);
        check("t6_no_queue_tx", 128'(tx_w[0]), 128'd1);
        check("t6_no_queue_busy", 128'(busy_w[0]), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
